phase_ctrl_unit: RTL and testbench
==================================

// Module: phase_ctrl_unit
// PURPOSE
//  Decodes the 6-bit one-hot phase vector from the CPU phase counter into registered
//  per-stage strobes. Stage order: fetch, decode, exec, mem, wb, pc-update.
//  Adds run/halt control at instruction boundaries and memory-wait replay.
//  Adds phase-integrity error detection and a retired-instruction counter.
//  Sits directly downstream of the phase counter and drives the datapath enables.
// PARAMETERS
//  CNT_W   16  width of retired-instruction counter instr_cnt
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  phase      in   6      one-hot phase; bit0=fetch ... bit5=pc-update
//  run        in   1      level request to start/resume execution
//  halt_req   in   1      request to stop at next instruction boundary
//  mem_ready  in   1      memory access complete; sampled in mem phase
//  st_fetch   out  1      IR-load strobe
//  st_decode  out  1      register-read strobe
//  st_exec    out  1      ALU strobe
//  st_mem     out  1      memory-access strobe
//  st_wb      out  1      register write-back strobe
//  st_pc      out  1      PC update strobe
//  replay     out  1      pulse: current instruction discarded and re-fetched
//  halted     out  1      core stopped at boundary
//  err        out  1      sticky phase-integrity error
//  instr_cnt  out  CNT_W  count of retired instructions
// BEHAVIOUR
//  Reset (reset=0): all outputs 0, instr_cnt=0, FSM=IDLE, repl_flag=0.
//  FSM states: IDLE, RUN, HALTED, ERROR.
//  - IDLE->RUN: run=1 while phase==6'b000001.
//  - RUN->HALTED: a cycle with phase==6'b100000 and halt_req=1; or halt_req is latched earlier.
//    halt_req is latched into a pending flag whenever RUN; the pending flag clears on entry to HALTED.
//  - HALTED->RUN: run=1, halt_req=0, phase==6'b000001.
//  - ERROR: from any state when phase is not one-hot (zero or >1 bit).
//    ERROR is left only by reset.
//  Strobes: 1-cycle registered latency.
//  - st_X=1 in cycle N+1 iff FSM==RUN in cycle N and phase selected stage X in cycle N.
//  - The entry cycle (IDLE/HALTED->RUN, phase0) produces st_fetch in the next cycle.
//  - At most one strobe high per cycle. All strobes are 0 in IDLE, HALTED and ERROR.
//  Memory wait: mem_ready is sampled in the cycle phase==bit3 while RUN.
//  - If mem_ready=0, repl_flag is set.
//  - With repl_flag set, st_wb and st_pc are suppressed.
//  - replay pulses (1 cycle) in place of st_pc; repl_flag then clears.
//  - PC is not advanced, so the same instruction re-executes.
//  Retire: each st_pc pulse increments instr_cnt by 1.
//  - Modulo 2^CNT_W; wraps from all-ones to 0 silently.
//  - Replayed instructions do not count.
//  Halt and replay together at bit5: replay still pulses, then the FSM goes to HALTED.
//  halted=1 in HALTED only. err=1 in ERROR only; all strobes and replay are forced 0.
//  Reset mid-instruction: immediate return to IDLE; the partial instruction is not counted.
// CONFIGURATION
//  PHASE_SEQ_CHECK_EN defined:
//  - Also checks the rotation order.
//  - In RUN, a phase that is not the rotate-left-by-1 of the previous phase -> ERROR.
//    Example: bit2 following bit0.
//  - Checking starts from the cycle after RUN entry.
//  PHASE_SEQ_CHECK_EN undefined: only the one-hot check; order is not examined.
// TESTING
//  1 Reset, run=1, phase cycles 000001..100000 x3, mem_ready=1
//    -> strobes in order fetch..pc, each 1 cycle after its phase; instr_cnt=3.
//  2 mem_ready=0 at phase bit3 of 2nd instruction
//    -> no st_wb/st_pc that instruction; replay=1 one cycle after bit5; instr_cnt=1 after 2 rounds.
//  3 halt_req pulsed at phase bit1
//    -> instruction completes (st_pc), halted=1; no strobes until run at phase bit0.
//  4 phase=6'b000110 injected -> err=1 next cycle, all strobes 0; stays until reset=0.
//  5 CNT_W=4, 16 retirements -> instr_cnt wraps 4'hF->4'h0.
//  6 With PHASE_SEQ_CHECK_EN: phase 000001 then 000100 -> err=1.
//    Without the macro: no error, st_exec issued.

Source files
------------

// File: rtl/phase_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : phase_ctrl_unit
// Description : Turns the one-hot phase vector from the CPU phase counter into
//               registered per-stage strobes (fetch, decode, exec, mem, wb,
//               pc-update). Adds run/halt control at instruction boundaries,
//               replay of an instruction whose memory access was not ready,
//               sticky phase-integrity error detection and a counter of
//               retired instructions.
//               Optional macro PHASE_SEQ_CHECK_EN: while running, also flags
//               a phase that is not the rotate-left-by-1 of the previous one.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_ctrl_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       phase,
    input  logic             run,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             st_fetch,
    output logic             st_decode,
    output logic             st_exec,
    output logic             st_mem,
    output logic             st_wb,
    output logic             st_pc,
    output logic             replay,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    localparam logic [5:0]       c_PH_FETCH = 6'b000001;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [5:0]       r_st;
    logic [5:0]       w_st_nxt;
    logic             r_replay;
    logic             w_replay_nxt;
    logic             r_repl;
    logic             r_halt_pend;
    logic [CNT_W-1:0] r_cnt;

    logic             w_onehot;
    logic             w_seq_err;
    logic             w_bad;
    logic             w_enter;
    logic             w_go;
    logic             w_halt_now;

    // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign w_onehot = (phase != 6'd0) && ((phase & (phase - 6'd1)) == 6'd0);

`ifdef PHASE_SEQ_CHECK_EN
    logic [5:0] r_prev_phase;

    // remember last phase so the rotation order can be checked while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_phase <= 6'd0;
        end else begin
            r_prev_phase <= phase;
        end
    end

    // only checked in RUN, so the entry cycle itself is never compared
    assign w_seq_err = (r_state == c_RUN) &&
                       (phase != {r_prev_phase[4:0], r_prev_phase[5]});
`else
    assign w_seq_err = 1'b0;
`endif

    assign w_bad = !w_onehot || w_seq_err;

    // start/resume only on the fetch phase so execution begins at a boundary
    assign w_enter = !w_bad && run && (phase == c_PH_FETCH) &&
                     ((r_state == c_IDLE) ||
                      ((r_state == c_HALTED) && !halt_req));

    // this cycle's phase produces a strobe next cycle
    assign w_go = !w_bad && ((r_state == c_RUN) || w_enter);

    // stop after the pc-update phase of the current instruction
    assign w_halt_now = (r_state == c_RUN) && !w_bad && phase[5] &&
                        (halt_req || r_halt_pend);

    // with a pending replay, write-back and PC update are withheld and the
    // replay pulse takes the place of the PC strobe
    assign w_st_nxt     = {w_go & phase[5] & !r_repl,
                           w_go & phase[4] & !r_repl,
                           {4{w_go}} & phase[3:0]};
    assign w_replay_nxt = w_go & phase[5] & r_repl;

    // next-state selection; ERROR is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ERROR) begin
            w_state_nxt = c_ERROR;
        end else if (w_bad) begin
            w_state_nxt = c_ERROR;
        end else if (w_enter) begin
            w_state_nxt = c_RUN;
        end else if (w_halt_now) begin
            w_state_nxt = c_HALTED;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // registered strobes and replay pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st     <= 6'd0;
            r_replay <= 1'b0;
        end else begin
            r_st     <= w_st_nxt;
            r_replay <= w_replay_nxt;
        end
    end

    // memory-wait replay flag: set on a not-ready mem phase, consumed at pc-update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_repl <= 1'b0;
        end else if (w_go && phase[3] && !mem_ready) begin
            r_repl <= 1'b1;
        end else if (w_go && phase[5]) begin
            r_repl <= 1'b0;
        end
    end

    // halt request captured during RUN until the boundary is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halt_pend <= 1'b0;
        end else if (r_state == c_RUN) begin
            if (w_state_nxt == c_HALTED) begin
                r_halt_pend <= 1'b0;
            end else if (halt_req) begin
                r_halt_pend <= 1'b1;
            end
        end
    end

    // retired-instruction counter, advances with each PC strobe, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_st_nxt[5]) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign st_fetch  = r_st[0];
    assign st_decode = r_st[1];
    assign st_exec   = r_st[2];
    assign st_mem    = r_st[3];
    assign st_wb     = r_st[4];
    assign st_pc     = r_st[5];
    assign replay    = r_replay;
    assign halted    = (r_state == c_HALTED);
    assign err       = (r_state == c_ERROR);
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phase_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_ctrl_unit
// Description : Directed self-checking bench for phase_ctrl_unit (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_ctrl_unit;

    logic       clk;
    logic       reset;
    logic [5:0] phase;
    logic       run;
    logic       halt_req;
    logic       mem_ready;
    logic       st_fetch, st_decode, st_exec, st_mem, st_wb, st_pc;
    logic       replay, halted, err;
    logic [3:0] instr_cnt;
    logic [5:0] st_vec;

    integer total;
    integer bad;

    phase_ctrl_unit #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .phase     (phase),
        .run       (run),
        .halt_req  (halt_req),
        .mem_ready (mem_ready),
        .st_fetch  (st_fetch),
        .st_decode (st_decode),
        .st_exec   (st_exec),
        .st_mem    (st_mem),
        .st_wb     (st_wb),
        .st_pc     (st_pc),
        .replay    (replay),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt)
    );

    assign st_vec = {st_pc, st_wb, st_mem, st_exec, st_decode, st_fetch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // apply a phase, let one rising edge pass, settle 1 time unit after it
    task automatic step(input logic [5:0] p);
        phase = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        run       = 1'b0;
        halt_req  = 1'b0;
        mem_ready = 1'b1;
        phase     = 6'b000001;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total = total + 1;
        if ({st_vec, replay, halted, err} !== 9'd0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got %b want 000000000", {st_vec, replay, halted, err});
        end
        total = total + 1;
        if (instr_cnt !== 4'd0) begin
            bad = bad + 1;
            $display("FAIL reset_cnt: got %0d want 0", instr_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [5:0] p;
        do_reset();
        run = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                p = 6'b000001 << i;
                step(p);
                total = total + 1;
                if ({st_vec, replay} !== {p, 1'b0}) begin
                    bad = bad + 1;
                    $display("FAIL seq_strobe r%0d i%0d: got %b want %b", r, i, {st_vec, replay}, {p, 1'b0});
                end
            end
        end
        total = total + 1;
        if (instr_cnt !== 4'd3) begin
            bad = bad + 1;
            $display("FAIL seq_cnt: got %0d want 3", instr_cnt);
        end
    endtask

    task automatic test_replay();
        logic [5:0] p;
        logic [5:0] exp_st;
        logic       exp_rp;
        do_reset();
        run = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                p         = 6'b000001 << i;
                mem_ready = !((r == 1) && (i == 3));
                step(p);
                exp_st = ((r == 1) && (i >= 4)) ? 6'd0 : p;
                exp_rp = (r == 1) && (i == 5);
                total = total + 1;
                if ({st_vec, replay} !== {exp_st, exp_rp}) begin
                    bad = bad + 1;
                    $display("FAIL replay_strobe r%0d i%0d: got %b want %b", r, i, {st_vec, replay}, {exp_st, exp_rp});
                end
            end
            mem_ready = 1'b1;
            if (r == 1) begin
                total = total + 1;
                if (instr_cnt !== 4'd1) begin
                    bad = bad + 1;
                    $display("FAIL replay_cnt2: got %0d want 1", instr_cnt);
                end
            end
        end
        total = total + 1;
        if (instr_cnt !== 4'd2) begin
            bad = bad + 1;
            $display("FAIL replay_cnt3: got %0d want 2", instr_cnt);
        end
    endtask

    task automatic test_halt();
        logic [5:0] p;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p        = 6'b000001 << i;
            halt_req = (i == 1);
            step(p);
            total = total + 1;
            if (st_vec !== p) begin
                bad = bad + 1;
                $display("FAIL halt_strobe i%0d: got %b want %b", i, st_vec, p);
            end
        end
        total = total + 1;
        if ({halted, st_pc} !== 2'b11) begin
            bad = bad + 1;
            $display("FAIL halt_enter: got halted/st_pc=%b want 11", {halted, st_pc});
        end
        run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(6'b000001 << i);
            total = total + 1;
            if ({st_vec, halted} !== 7'b0000001) begin
                bad = bad + 1;
                $display("FAIL halt_idle i%0d: got %b want 0000001", i, {st_vec, halted});
            end
        end
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = 6'b000001 << i;
            step(p);
            total = total + 1;
            if ({st_vec, halted} !== {p, 1'b0}) begin
                bad = bad + 1;
                $display("FAIL halt_resume i%0d: got %b want %b", i, {st_vec, halted}, {p, 1'b0});
            end
        end
        total = total + 1;
        if (instr_cnt !== 4'd2) begin
            bad = bad + 1;
            $display("FAIL halt_cnt: got %0d want 2", instr_cnt);
        end
    endtask

    task automatic test_error();
        do_reset();
        run = 1'b1;
        step(6'b000001);
        step(6'b000010);
        step(6'b000110);
        total = total + 1;
        if ({err, st_vec, replay} !== 8'b10000000) begin
            bad = bad + 1;
            $display("FAIL err_set: got %b want 10000000", {err, st_vec, replay});
        end
        step(6'b001000);
        step(6'b000001);
        step(6'b000010);
        total = total + 1;
        if ({err, st_vec, halted} !== 8'b10000000) begin
            bad = bad + 1;
            $display("FAIL err_sticky: got %b want 10000000", {err, st_vec, halted});
        end
        total = total + 1;
        if (instr_cnt !== 4'd0) begin
            bad = bad + 1;
            $display("FAIL err_cnt: got %0d want 0", instr_cnt);
        end
        // asynchronous clear away from any clock edge
        #2;
        reset = 1'b0;
        #1;
        total = total + 1;
        if (err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL err_async_clr: got %b want 0", err);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        // all-zero phase also counts as an integrity error
        step(6'b000000);
        total = total + 1;
        if (err !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL err_zero: got %b want 1", err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 6; i++) begin
                step(6'b000001 << i);
            end
            if (r == 14) begin
                total = total + 1;
                if (instr_cnt !== 4'hF) begin
                    bad = bad + 1;
                    $display("FAIL wrap_max: got %h want f", instr_cnt);
                end
            end
        end
        total = total + 1;
        if (instr_cnt !== 4'h0) begin
            bad = bad + 1;
            $display("FAIL wrap_zero: got %h want 0", instr_cnt);
        end
        // partial instruction interrupted by reset is not counted
        step(6'b000001);
        step(6'b000010);
        reset = 1'b0;
        #1;
        total = total + 1;
        if ({instr_cnt, st_vec} !== 10'd0) begin
            bad = bad + 1;
            $display("FAIL midreset: got %b want 0", {instr_cnt, st_vec});
        end
        reset = 1'b1;
    endtask

    task automatic test_order();
        do_reset();
        run = 1'b1;
        step(6'b000001);
        step(6'b000100);
`ifdef PHASE_SEQ_CHECK_EN
        total = total + 1;
        if ({err, st_vec} !== 7'b1000000) begin
            bad = bad + 1;
            $display("FAIL order_err: got %b want 1000000", {err, st_vec});
        end
`else
        total = total + 1;
        if ({err, st_vec} !== 7'b0000100) begin
            bad = bad + 1;
            $display("FAIL order_noerr: got %b want 0000100", {err, st_vec});
        end
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        run       = 1'b0;
        halt_req  = 1'b0;
        mem_ready = 1'b1;
        phase     = 6'b000001;
        test_reset();
        test_sequence();
        test_replay();
        test_halt();
        test_error();
        test_wrap();
        test_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
